adder_entry_sequencer: RTL and testbench

//  Key-driven controller for the keypad decimal adder. Takes decoded key events from the keypad

---
 rtl/keyboard_adder_pkg.sv | 21 ++
 rtl/bcd_adder_n.sv | 32 +++
 rtl/adder_entry_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_adder_entry_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_adder_pkg.sv
// Shared definitions for the keypad decimal adder.
//   - key codes for the non-digit keys (digits are codes 0-9)
//   - sequencer state encoding
//   - default BCD code that blanks a display digit
package keyboard_adder_pkg;

    localparam logic [3:0] KEY_PLUS = 4'd10;
    localparam logic [3:0] KEY_EQ   = 4'd11;
    localparam logic [3:0] KEY_CLR  = 4'd12;
    localparam logic [3:0] KEY_BS   = 4'd13;

    localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        StEnterA = 2'd0,
        StEnterB = 2'd1,
        StCalc   = 2'd2,
        StShow   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/bcd_adder_n.sv
// Combinational ripple-carry BCD adder.
//   a_i, b_i : DIGITS packed BCD nibbles each, digit 0 in [3:0]
//   sum_o    : DIGITS+1 packed BCD nibbles; the top nibble is the final decimal carry (0 or 1)
module bcd_adder_n #(
    parameter int unsigned DIGITS = 2
) (
    input  logic [4*DIGITS-1:0]     a_i,
    input  logic [4*DIGITS-1:0]     b_i,
    output logic [4*(DIGITS+1)-1:0] sum_o
);

    always_comb begin : ripple
        logic [4:0] dsum;
        logic       carry;
        sum_o = '0;
        carry = 1'b0;
        dsum  = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dsum = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, carry};
            // Past 9 the binary digit sum skips the six unused codes; +6 wraps it back into BCD.
            if (dsum > 5'd9) begin
                sum_o[4*i +: 4] = dsum[3:0] + 4'd6;
                carry           = 1'b1;
            end else begin
                sum_o[4*i +: 4] = dsum[3:0];
                carry           = 1'b0;
            end
        end
        sum_o[4*DIGITS +: 4] = {3'b0, carry};
    end

endmodule

// File: rtl/adder_entry_sequencer.sv
// Key-driven controller for the keypad decimal adder.
// Sequences operand A entry, operand B entry, a one-cycle BCD add and result display, and
// drives a packed BCD word (leading zeros blanked, digit 0 always shown) to the display driver.
//   clk       : system clock
//   clr       : synchronous active-high reset
//   key_valid : one-cycle strobe qualifying key_code
//   key_code  : 0-9 digit, 10 '+', 11 '=', 12 CLEAR, 13 BACKSPACE, 14-15 unused
//   disp_bcd  : packed BCD display word, digit 0 in [3:0], BLANK_CODE = off
//   sel_b     : high while operand B is being entered
//   state_o   : 0 ENTER_A, 1 ENTER_B, 2 CALC, 3 SHOW
//   sum_valid : one-cycle pulse when a new sum is latched
//   key_drop  : one-cycle pulse when a valid key is ignored
// All outputs are registered. Define ADDER_SEQ_BACKSPACE_EN to enable BACKSPACE editing;
// otherwise BACKSPACE is dropped like an unused code.
module adder_entry_sequencer
    import keyboard_adder_pkg::*;
#(
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned DISP_DIGITS = 8,
    parameter logic [3:0]  BLANK_CODE  = DEFAULT_BLANK_CODE
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     key_valid,
    input  logic [3:0]               key_code,
    output logic [4*DISP_DIGITS-1:0] disp_bcd,
    output logic                     sel_b,
    output logic [1:0]               state_o,
    output logic                     sum_valid,
    output logic                     key_drop
);

    localparam int unsigned OP_W  = 4 * DIGITS;
    localparam int unsigned SUM_W = 4 * (DIGITS + 1);
    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);

    seq_state_t             state_q, state_d;
    logic [OP_W-1:0]        a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]       cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [SUM_W-1:0]       sum_q, sum_d, add_sum, disp_val;
    logic                   drop_d, sum_valid_d, is_digit;
    logic [4*DISP_DIGITS-1:0] disp_q;
    logic                   sel_b_q, sum_valid_q, drop_q;

    // Right-aligns a value on the display, blanking leading zeros and unused upper positions.
    function automatic logic [4*DISP_DIGITS-1:0] blank_fmt(input logic [SUM_W-1:0] val);
        logic [4*DISP_DIGITS-1:0] r;
        logic                     lead;
        r    = {DISP_DIGITS{BLANK_CODE}};
        lead = 1'b1;
        for (int i = int'(DIGITS); i >= 0; i--) begin
            if (lead && (val[4*i +: 4] == 4'd0) && (i != 0)) begin
                r[4*i +: 4] = BLANK_CODE;
            end else begin
                lead        = 1'b0;
                r[4*i +: 4] = val[4*i +: 4];
            end
        end
        return r;
    endfunction

    bcd_adder_n #(
        .DIGITS (DIGITS)
    ) u_bcd_adder (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (add_sum)
    );

    assign is_digit = (key_code <= 4'd9);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        sum_d       = sum_q;
        drop_d      = 1'b0;
        sum_valid_d = 1'b0;

        unique case (state_q)
            StEnterA: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (cnt_a_q == CNT_MAX) begin
                            drop_d = 1'b1;
                        end else begin
                            a_d     = (a_q << 4) | OP_W'(key_code);
                            cnt_a_d = cnt_a_q + 1'b1;
                        end
                    end else if (key_code == KEY_PLUS) begin
                        state_d = StEnterB;
                        b_d     = '0;
                        cnt_b_d = '0;
                    end
`ifdef ADDER_SEQ_BACKSPACE_EN
                    else if ((key_code == KEY_BS) && (cnt_a_q != '0)) begin
                        a_d     = a_q >> 4;
                        cnt_a_d = cnt_a_q - 1'b1;
                    end
`endif
                    else begin
                        drop_d = 1'b1;
                    end
                end
            end
            StEnterB: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (cnt_b_q == CNT_MAX) begin
                            drop_d = 1'b1;
                        end else begin
                            b_d     = (b_q << 4) | OP_W'(key_code);
                            cnt_b_d = cnt_b_q + 1'b1;
                        end
                    end else if (key_code == KEY_EQ) begin
                        state_d = StCalc;
                    end
`ifdef ADDER_SEQ_BACKSPACE_EN
                    else if ((key_code == KEY_BS) && (cnt_b_q != '0)) begin
                        b_d     = b_q >> 4;
                        cnt_b_d = cnt_b_q - 1'b1;
                    end
`endif
                    else begin
                        drop_d = 1'b1;
                    end
                end
            end
            StCalc: begin
                state_d     = StShow;
                sum_d       = add_sum;
                sum_valid_d = 1'b1;
                drop_d      = key_valid;
            end
            StShow: begin
                if (key_valid) begin
                    if (is_digit) begin
                        state_d = StEnterA;
                        a_d     = OP_W'(key_code);
                        cnt_a_d = CNT_W'(1);
                        b_d     = '0;
                        cnt_b_d = '0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
        endcase

        // CLEAR overrides everything above, including completion of CALC.
        if (key_valid && (key_code == KEY_CLR)) begin
            state_d     = StEnterA;
            a_d         = '0;
            b_d         = '0;
            cnt_a_d     = '0;
            cnt_b_d     = '0;
            sum_d       = '0;
            drop_d      = 1'b0;
            sum_valid_d = 1'b0;
        end
    end

    // Display follows the next state so it updates together with the accepting key.
    always_comb begin
        unique case (state_d)
            StEnterA: disp_val = {4'h0, a_d};
            StEnterB: disp_val = {4'h0, b_d};
            default:  disp_val = sum_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= StEnterA;
            a_q         <= '0;
            b_q         <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            sum_q       <= '0;
            disp_q      <= blank_fmt('0);
            sel_b_q     <= 1'b0;
            sum_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            sum_q       <= sum_d;
            disp_q      <= blank_fmt(disp_val);
            sel_b_q     <= (state_d == StEnterB);
            sum_valid_q <= sum_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign disp_bcd  = disp_q;
    assign sel_b     = sel_b_q;
    assign state_o   = state_q;
    assign sum_valid = sum_valid_q;
    assign key_drop  = drop_q;

endmodule

// File: tb/tb_adder_entry_sequencer.sv
// Bench for adder_entry_sequencer: decimal-integer reference model, per-cycle compare on the
// falling edge, directed key sequences with literal expectations, then random key traffic.
module tb_adder_entry_sequencer;

    localparam int MAXV = 100;  // 10**DIGITS for the default DIGITS=2
`ifdef ADDER_SEQ_BACKSPACE_EN
    localparam bit BS_EN = 1'b1;
`else
    localparam bit BS_EN = 1'b0;
`endif

    logic        clk;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] disp_bcd;
    logic        sel_b;
    logic [1:0]  state_o;
    logic        sum_valid;
    logic        key_drop;

    int vectors  = 0;
    int errors   = 0;
    int sv_count = 0;
    bit chk_en   = 1'b0;

    // Reference model: operands and sum held as plain decimal integers.
    int m_st  = 0;  // 0 ENTER_A, 1 ENTER_B, 2 CALC, 3 SHOW
    int m_a   = 0;
    int m_b   = 0;
    int m_ca  = 0;
    int m_cb  = 0;
    int m_sum = 0;
    bit m_sv  = 1'b0;
    bit m_drop = 1'b0;

    adder_entry_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .disp_bcd  (disp_bcd),
        .sel_b     (sel_b),
        .state_o   (state_o),
        .sum_valid (sum_valid),
        .key_drop  (key_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_disp(input int v);
        logic [31:0] r;
        int p;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || v / p > 0) r[4*i +: 4] = 4'((v / p) % 10);
            else                     r[4*i +: 4] = 4'hF;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int shown_value();
        if (m_st == 0) return m_a;
        if (m_st == 1) return m_b;
        return m_sum;
    endfunction

    task automatic model_edge(input bit c, input bit v, input int k);
        m_sv   = 1'b0;
        m_drop = 1'b0;
        if (c || (v && k == 12)) begin
            m_st = 0; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_sum = 0;
            return;
        end
        if (m_st == 2) begin
            m_sum  = m_a + m_b;
            m_st   = 3;
            m_sv   = 1'b1;
            m_drop = v;
            return;
        end
        if (!v) return;
        case (m_st)
            0: begin
                if (k <= 9) begin
                    if (m_ca == 2) m_drop = 1'b1;
                    else begin m_a = (m_a * 10 + k) % MAXV; m_ca++; end
                end else if (k == 10) begin
                    m_st = 1; m_b = 0; m_cb = 0;
                end else if (k == 13 && BS_EN && m_ca > 0) begin
                    m_a = m_a / 10; m_ca--;
                end else m_drop = 1'b1;
            end
            1: begin
                if (k <= 9) begin
                    if (m_cb == 2) m_drop = 1'b1;
                    else begin m_b = (m_b * 10 + k) % MAXV; m_cb++; end
                end else if (k == 11) begin
                    m_st = 2;
                end else if (k == 13 && BS_EN && m_cb > 0) begin
                    m_b = m_b / 10; m_cb--;
                end else m_drop = 1'b1;
            end
            default: begin
                if (k <= 9) begin
                    m_st = 0; m_a = k; m_ca = 1; m_b = 0; m_cb = 0;
                end else m_drop = 1'b1;
            end
        endcase
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state_o", 32'(state_o), 32'(m_st));
            chk("disp_bcd", disp_bcd, exp_disp(shown_value()));
            chk("sel_b", 32'(sel_b), 32'(m_st == 1));
            chk("sum_valid", 32'(sum_valid), 32'(m_sv));
            chk("key_drop", 32'(key_drop), 32'(m_drop));
        end
    end

    task automatic apply(input logic c, input logic v, input logic [3:0] k);
        clr       = c;
        key_valid = v;
        key_code  = k;
        @(posedge clk);
        model_edge(c, v, int'(k));
        @(negedge clk);
        if (sum_valid === 1'b1) sv_count++;
        clr       = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        apply(1'b0, 1'b1, k);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 4'd0);
    endtask

    int sv0;

    initial begin
        clr       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        chk_en    = 1'b1;  // first falling edge follows the first (reset) rising edge

        apply(1'b1, 1'b0, 4'd0);
        apply(1'b1, 1'b1, 4'd5);
        chk("rst_disp", disp_bcd, 32'hFFFF_FFF0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_sel_b", 32'(sel_b), 32'd0);

        // 47 + 58 = 105
        key(4'd4);
        key(4'd7);
        chk("disp_47", disp_bcd, 32'hFFFF_FF47);
        key(4'd10);
        chk("sel_b_in_b", 32'(sel_b), 32'd1);
        key(4'd5);
        key(4'd8);
        sv0 = sv_count;
        key(4'd11);
        chk("calc_state", 32'(state_o), 32'd2);
        idle();
        chk("sum_105", disp_bcd, 32'hFFFF_F105);
        chk("show_state", 32'(state_o), 32'd3);
        idle();
        idle();
        chk("sum_valid_once", 32'(sv_count - sv0), 32'd1);
        key(4'd11);
        chk("show_eq_drop", 32'(key_drop), 32'd1);
        key(4'd2);
        chk("show_digit_disp", disp_bcd, 32'hFFFF_FFF2);
        chk("show_digit_state", 32'(state_o), 32'd0);
        key(4'd11);
        chk("eq_in_a_drop", 32'(key_drop), 32'd1);
        chk("eq_in_a_state", 32'(state_o), 32'd0);

        // 99 + 99 = 198 with operand overflow
        key(4'd12);
        key(4'd9);
        key(4'd9);
        key(4'd9);
        chk("third_9_drop", 32'(key_drop), 32'd1);
        chk("a_99", disp_bcd, 32'hFFFF_FF99);
        key(4'd10);
        key(4'd9);
        key(4'd9);
        key(4'd10);
        chk("plus_in_b_drop", 32'(key_drop), 32'd1);
        chk("plus_in_b_state", 32'(state_o), 32'd1);
        key(4'd11);
        idle();
        chk("sum_198", disp_bcd, 32'hFFFF_F198);

        // CLEAR on the CALC cycle
        key(4'd1);
        key(4'd10);
        key(4'd2);
        key(4'd11);
        sv0 = sv_count;
        key(4'd12);
        chk("clr_calc_state", 32'(state_o), 32'd0);
        chk("clr_calc_disp", disp_bcd, 32'hFFFF_FFF0);
        idle();
        chk("clr_calc_no_sv", 32'(sv_count - sv0), 32'd0);

        // Backspace
        key(4'd3);
        key(4'd6);
        key(4'd13);
`ifdef ADDER_SEQ_BACKSPACE_EN
        chk("bs_disp_3", disp_bcd, 32'hFFFF_FFF3);
        key(4'd13);
        chk("bs_disp_0", disp_bcd, 32'hFFFF_FFF0);
        key(4'd13);
        chk("bs_empty_drop", 32'(key_drop), 32'd1);
`else
        chk("bs_drop", 32'(key_drop), 32'd1);
        chk("bs_disp_36", disp_bcd, 32'hFFFF_FF36);
`endif
        key(4'd14);
        chk("code14_drop", 32'(key_drop), 32'd1);

        // Random key traffic
        for (int n = 0; n < 3000; n++) begin
            logic       c, v;
            logic [3:0] k;
            int         r;
            c = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 19));
            if (r < 10)      k = 4'(r);
            else if (r < 12) k = 4'd10;
            else if (r < 14) k = 4'd11;
            else             k = 4'(r - 4);
            apply(c, v, k);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
